// File: rtl/aes_mode_pkg.sv
// Shared types and constants for the AES block-mode sequencer.
package aes_mode_pkg;

    typedef enum logic [2:0] {
        IDLE,
        KINIT,
        KWAIT,
        ACCEPT,
        BSTART,
        BWAIT,
        OUTPUT
    } state_t;

    localparam logic MODE_CBC = 1'b0;
    localparam logic MODE_CTR = 1'b1;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_KEY_W   = 256;

endpackage

// File: rtl/aes_mode_chain.sv
// Chaining datapath: IV/counter register, input block register, core block mux and result register.
// CTR datapath is present only when AES_MODE_CTR_EN is defined.
module aes_mode_chain
    import aes_mode_pkg::*;
#(
    parameter int CTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load_iv,
    input  logic [AES_BLOCK_W-1:0] iv,
    input  logic                   load_data,
    input  logic [AES_BLOCK_W-1:0] in_data,
    input  logic                   capture,
    input  logic                   ctr,
    input  logic                   encdec,
    input  logic [AES_BLOCK_W-1:0] core_result,
    output logic [AES_BLOCK_W-1:0] core_block,
    output logic [AES_BLOCK_W-1:0] out_data
);

    logic [AES_BLOCK_W-1:0] chain_reg;
    logic [AES_BLOCK_W-1:0] data_reg;
    logic [AES_BLOCK_W-1:0] ctr_inc;
    logic                   ctr_on;

`ifdef AES_MODE_CTR_EN
    // Only the low CTR_WIDTH bits count; the carry out of them is dropped.
    localparam logic [AES_BLOCK_W-1:0] LOW_MASK = {AES_BLOCK_W{1'b1}} >> (AES_BLOCK_W - CTR_WIDTH);
    assign ctr_on  = ctr;
    assign ctr_inc = (chain_reg & ~LOW_MASK) | ((chain_reg + 128'd1) & LOW_MASK);
`else
    logic unused_ctr;
    assign unused_ctr = ctr ^ (CTR_WIDTH > 0);
    assign ctr_on     = 1'b0;
    assign ctr_inc    = chain_reg;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain_reg  <= '0;
            data_reg   <= '0;
            core_block <= '0;
            out_data   <= '0;
        end else begin
            if (load_iv)
                chain_reg <= iv;
            else if (capture)
                chain_reg <= ctr_on ? ctr_inc : (encdec ? core_result : data_reg);
            // core_block is fixed at accept so it is stable through the whole core operation
            if (load_data) begin
                data_reg   <= in_data;
                core_block <= ctr_on ? chain_reg : (encdec ? (in_data ^ chain_reg) : in_data);
            end
            if (capture)
                out_data <= ctr_on ? (core_result ^ data_reg)
                                   : (encdec ? core_result : (core_result ^ chain_reg));
        end
    end

endmodule

// File: rtl/aes_mode_ctrl.sv
// CBC (optional CTR via AES_MODE_CTR_EN) mode sequencer driving aes_core, one block in flight.
module aes_mode_ctrl
    import aes_mode_pkg::*;
#(
    parameter int GUARD_CYCLES = 2,
    parameter int CTR_WIDTH    = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         abort,
    input  logic [255:0] key,
    input  logic         keylen,
    input  logic         encdec,
    input  logic         mode,
    input  logic [127:0] iv,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         out_last,
    output logic         busy,
    output logic         done,
    output logic         core_init,
    output logic         core_next,
    output logic         core_encdec,
    output logic         core_keylen,
    output logic [255:0] core_key,
    output logic [127:0] core_block,
    input  logic         core_ready,
    input  logic         core_valid,
    input  logic [127:0] core_result
);

    localparam int GW = (GUARD_CYCLES < 1) ? 1 : $clog2(GUARD_CYCLES + 1);

    state_t               state, state_nxt;
    logic [GW-1:0]        guard;
    logic [AES_KEY_W-1:0] key_r;
    logic                 keylen_r, encdec_r, ctr_r, last_r;
    logic                 guard_ok, load_iv, in_hs, out_hs, capture;

    // core_ready alone marks completion; core_valid carries no extra information here
    logic unused_core_valid;
    assign unused_core_valid = core_valid;

    assign guard_ok = (guard == '0) && core_ready;
    assign load_iv  = (state == IDLE) && start && !abort;
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;
    assign capture  = (state == BWAIT) && guard_ok && !abort;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = KINIT;
                KINIT:   state_nxt = KWAIT;
                KWAIT:   if (guard_ok) state_nxt = ACCEPT;
                ACCEPT:  if (in_valid) state_nxt = BSTART;
                BSTART:  state_nxt = BWAIT;
                BWAIT:   if (guard_ok) state_nxt = OUTPUT;
                OUTPUT:  if (out_ready) state_nxt = last_r ? IDLE : ACCEPT;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Handshake outputs fall with abort so no transfer is seen on the aborting edge
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        core_init = 1'b0;
        core_next = 1'b0;
        busy      = (state != IDLE);
        case (state)
            KINIT:   core_init = 1'b1;
            ACCEPT:  in_ready  = !abort;
            BSTART:  core_next = 1'b1;
            OUTPUT:  out_valid = !abort;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            guard    <= '0;
            key_r    <= '0;
            keylen_r <= 1'b0;
            encdec_r <= 1'b0;
            last_r   <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (load_iv) begin
                key_r    <= key;
                keylen_r <= keylen;
                encdec_r <= encdec;
            end
            if (state == KINIT || state == BSTART)
                guard <= GW'(GUARD_CYCLES);
            else if ((state == KWAIT || state == BWAIT) && guard != '0)
                guard <= guard - GW'(1);
            if (in_hs)
                last_r <= in_last;
            done <= out_hs && last_r;
        end
    end

`ifdef AES_MODE_CTR_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     ctr_r <= 1'b0;
        else if (load_iv) ctr_r <= (mode == MODE_CTR);
    end
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign ctr_r       = 1'b0;
`endif

    assign core_key    = key_r;
    assign core_keylen = keylen_r;
    assign core_encdec = ctr_r | encdec_r;
    assign out_last    = last_r;

    aes_mode_chain #(
        .CTR_WIDTH(CTR_WIDTH)
    ) u_chain (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_iv    (load_iv),
        .iv         (iv),
        .load_data  (in_hs),
        .in_data    (in_data),
        .capture    (capture),
        .ctr        (ctr_r),
        .encdec     (encdec_r),
        .core_result(core_result),
        .core_block (core_block),
        .out_data   (out_data)
    );

endmodule

// File: tb/tb_aes_mode_ctrl.sv
// Directed bench for aes_mode_ctrl with a behavioural aes_core stand-in (known vectors + XOR fallback cipher).
module tb_aes_mode_ctrl;

    localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] IV     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1     = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] P2     = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] C1     = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] CBC_IN = 128'h6bc0bce12a459991e134741a7f9e1925;
    localparam logic [127:0] CTR0   = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] KS0    = 128'hec8cdf7398607cb0f2d21675ea9ea1e4;
    localparam logic [127:0] MASK   = 128'ha5a5_5a5a_0f0f_f0f0_3c3c_c3c3_9696_6969;
    localparam int           LAT    = 5;

    logic         clk = 1'b0, reset_n = 1'b0;
    logic         start = 0, abort = 0, keylen = 0, encdec = 0, mode = 0;
    logic [255:0] key = '0;
    logic [127:0] iv = '0, in_data = '0;
    logic         in_valid = 0, in_last = 0, out_ready = 0;
    logic         in_ready, out_valid, out_last, busy, done;
    logic [127:0] out_data, core_block;
    logic         core_init, core_next, core_encdec, core_keylen;
    logic [255:0] core_key;
    logic         core_ready, core_valid;
    logic [127:0] core_result;

    int           n_chk = 0, n_fail = 0, n_next = 0;
    int           core_cnt;
    logic [127:0] blk_cap, last_next_block;
    logic         ed_cap;

    always #5 clk = ~clk;

    aes_mode_ctrl dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .key(key),
        .keylen(keylen), .encdec(encdec), .mode(mode), .iv(iv),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done), .core_init(core_init), .core_next(core_next),
        .core_encdec(core_encdec), .core_keylen(core_keylen), .core_key(core_key),
        .core_block(core_block), .core_ready(core_ready), .core_valid(core_valid),
        .core_result(core_result)
    );

    function automatic logic [127:0] cipher(input logic [127:0] b, input logic e);
        if (e && b == CBC_IN) return C1;
        if (!e && b == C1)    return CBC_IN;
        if (e && b == CTR0)   return KS0;
        return b ^ MASK;
    endfunction

    // Core stand-in: ready drops the cycle after init/next, result appears LAT cycles later
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_ready <= 1'b1; core_valid <= 1'b0; core_result <= '0; core_cnt <= 0;
            blk_cap <= '0; ed_cap <= 1'b0; last_next_block <= '0;
        end else if (core_init) begin
            core_ready <= 1'b0; core_valid <= 1'b0; core_cnt <= LAT;
        end else if (core_next) begin
            core_ready <= 1'b0; core_valid <= 1'b0; core_cnt <= LAT;
            blk_cap <= core_block; ed_cap <= core_encdec; last_next_block <= core_block;
            n_next <= n_next + 1;
        end else if (core_cnt != 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) begin
                core_ready <= 1'b1; core_valid <= 1'b1; core_result <= cipher(blk_cap, ed_cap);
            end
        end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic start_msg(input logic [255:0] k, input logic kl, input logic ed,
                             input logic md, input logic [127:0] ivv);
        key = k; keylen = kl; encdec = ed; mode = md; iv = ivv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_block(input string tag, input logic [127:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1; in_data = d; in_last = l;
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        check({tag, "_in_ready"}, 256'(in_ready), 256'(1));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic get_block(input string tag, input logic [127:0] exp, input logic exp_last);
        int n = 0;
        out_ready = 1'b1;
        while (!out_valid && n < 200) begin @(negedge clk); n++; end
        check({tag, "_valid"}, 256'(out_valid), 256'(1));
        check({tag, "_data"}, 256'(out_data), 256'(exp));
        check({tag, "_last"}, 256'(out_last), 256'(exp_last));
        @(negedge clk);
        out_ready = 1'b0;
        if (exp_last) begin
            check({tag, "_done"}, 256'(done), 256'(1));
            check({tag, "_idle"}, 256'(busy), 256'(0));
            @(negedge clk);
            check({tag, "_done_1cyc"}, 256'(done), 256'(0));
        end
    endtask

    logic [127:0] c2, held;
    logic         bad_hold, bad_rdy, seen;
    int           nx0;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_in_ready",  256'(in_ready),  256'(0));
        check("rst_busy",      256'(busy),      256'(0));
        check("rst_core_ctl",  256'({core_init, core_next, core_encdec, core_keylen, done}), 256'(0));
        check("rst_out_data",  256'(out_data),  256'(0));
        check("rst_core_key",  core_key,        256'(0));
        reset_n = 1'b1;
        @(negedge clk);

        // CBC-AES128 single-block known vector
        start_msg(KEY128, 1'b0, 1'b1, 1'b0, IV);
        check("cbc_busy", 256'(busy), 256'(1));
        send_block("cbc1", P1, 1'b1);
        check("cbc_core_block", 256'(core_block), 256'(CBC_IN));
        check("cbc_core_key", core_key, KEY128);
        get_block("cbc1", C1, 1'b1);

        // Two-block encrypt, then decrypt it back; block 2 chains on C1
        c2 = (P2 ^ C1) ^ MASK;
        start_msg(KEY256, 1'b1, 1'b1, 1'b0, IV);
        check("enc2_keylen", 256'(core_keylen), 256'(1));
        send_block("enc2a", P1, 1'b0);
        get_block("enc2a", C1, 1'b0);
        send_block("enc2b", P2, 1'b1);
        get_block("enc2b", c2, 1'b1);
        start_msg(KEY256, 1'b1, 1'b0, 1'b0, IV);
        check("dec_encdec", 256'(core_encdec), 256'(0));
        send_block("dec2a", C1, 1'b0);
        check("dec_core_block", 256'(core_block), 256'(C1));
        get_block("dec2a", P1, 1'b0);
        send_block("dec2b", c2, 1'b1);
        check("dec_core_block2", 256'(core_block), 256'(c2));
        get_block("dec2b", P2, 1'b1);

        // Output backpressure for 20 cycles
        start_msg(KEY128, 1'b0, 1'b1, 1'b0, IV);
        send_block("bp", P1, 1'b1);
        for (int i = 0; i < 200 && !out_valid; i++) @(negedge clk);
        held = out_data; nx0 = n_next; bad_hold = 1'b0; bad_rdy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!out_valid || out_data !== held) bad_hold = 1'b1;
            if (in_ready || core_next) bad_rdy = 1'b1;
            @(negedge clk);
        end
        check("bp_hold", 256'(bad_hold), 256'(0));
        check("bp_no_accept", 256'(bad_rdy), 256'(0));
        check("bp_no_next", 256'(n_next), 256'(nx0));
        get_block("bp", C1, 1'b1);

        // Abort in BWAIT
        start_msg(KEY128, 1'b0, 1'b1, 1'b0, IV);
        send_block("abt", P1, 1'b1);
        check("abt_bstart_next", 256'(core_next), 256'(1));
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abt_busy", 256'(busy), 256'(0));
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid || done || busy) seen = 1'b1;
            @(negedge clk);
        end
        check("abt_quiet", 256'(seen), 256'(0));
        // abort beats a simultaneous start
        abort = 1'b1;
        start_msg(KEY128, 1'b0, 1'b1, 1'b0, IV);
        abort = 1'b0;
        check("abt_start_ignored", 256'(busy), 256'(0));
        start_msg(KEY128, 1'b0, 1'b1, 1'b0, IV);
        send_block("abt_re", P1, 1'b1);
        get_block("abt_re", C1, 1'b1);

`ifdef AES_MODE_CTR_EN
        // CTR known vector; encdec=0 must still run the core forward
        start_msg(KEY128, 1'b0, 1'b0, 1'b1, CTR0);
        check("ctr_encdec", 256'(core_encdec), 256'(1));
        send_block("ctr1", P1, 1'b0);
        check("ctr_core_block", 256'(core_block), 256'(CTR0));
        get_block("ctr1", 128'h874d6191b620e3261bef6864990db6ce, 1'b0);
        send_block("ctr2", P2, 1'b1);
        check("ctr_next_block", 256'(last_next_block), 256'(128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00));
        get_block("ctr2", (128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00 ^ MASK) ^ P2, 1'b1);
        // Low-word wrap
        start_msg(KEY128, 1'b0, 1'b1, 1'b1, 128'h0123456789abcdef01234567ffffffff);
        send_block("wrap1", P1, 1'b0);
        get_block("wrap1", (128'h0123456789abcdef01234567ffffffff ^ MASK) ^ P1, 1'b0);
        send_block("wrap2", P2, 1'b1);
        check("wrap_next_block", 256'(last_next_block), 256'(128'h0123456789abcdef0123456700000000));
        get_block("wrap2", (128'h0123456789abcdef0123456700000000 ^ MASK) ^ P2, 1'b1);
`else
        // Without CTR support mode=1 runs as CBC
        start_msg(KEY128, 1'b0, 1'b1, 1'b1, IV);
        send_block("nomode", P1, 1'b1);
        check("nomode_core_block", 256'(core_block), 256'(CBC_IN));
        get_block("nomode", C1, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_mode_ctrl.md
Name: aes_mode_ctrl

Overview:
- Block-cipher mode sequencer in front of aes_core. Owns the core's init/next/encdec/keylen/key/block pins.
- Takes a key and IV once per message, runs key expansion, then streams 128-bit blocks through the core in CBC mode (CTR mode optional).
- Applies chaining XOR and IV/counter update, and presents results on a valid/ready output stream.
- Sits between a DMA/stream front-end and aes_core, replacing register-poked single-block operation.

Parameters:
- GUARD_CYCLES, 2: cycles after an init/next pulse during which core_ready is ignored (covers the core's registered ready drop).
- CTR_WIDTH, 32: low-order counter bits incremented per block in CTR mode; upper bits are never modified.

Ports:
- clk  in  1  clock
- reset_n  in  1  async active-low reset
- start  in  1  1-cycle pulse; latches key, keylen, encdec, mode, iv; ignored unless in IDLE
- abort  in  1  synchronous; forces IDLE from any state
- key  in  256  key; a 128-bit key occupies [255:128]
- keylen  in  1  0=128-bit, 1=256-bit
- encdec  in  1  1=encrypt, 0=decrypt (CBC only)
- mode  in  1  0=CBC, 1=CTR (CTR requires AES_MODE_CTR_EN)
- iv  in  128  IV (CBC) or initial counter block (CTR)
- in_valid  in  1  input block valid
- in_ready  out  1  input block accepted when in_valid&&in_ready
- in_data  in  128  input block
- in_last  in  1  marks final block of message
- out_valid  out  1  result valid
- out_ready  in  1  sink accepts
- out_data  out  128  result block
- out_last  out  1  copy of accepted in_last
- busy  out  1  high in every state except IDLE
- done  out  1  1-cycle pulse after the last block handshakes on the output
- core_init, core_next, core_encdec, core_keylen  out  1 each  to aes_core
- core_key  out  256  to aes_core
- core_block  out  128  to aes_core
- core_ready, core_valid  in  1 each  from aes_core
- core_result  in  128  from aes_core

Behaviour:
- Reset: all outputs 0, state IDLE; key/iv/chain/data registers cleared.
- States: IDLE -> KINIT -> KWAIT -> ACCEPT -> BSTART -> BWAIT -> OUTPUT -> ACCEPT, or OUTPUT -> IDLE after the last block.
- IDLE: on start, latch config; chain_reg=iv; go to KINIT.
- KINIT: core_init=1 for exactly one cycle; load guard counter with GUARD_CYCLES; go to KWAIT.
- KWAIT: guard counts down; once guard==0 and core_ready==1, go to ACCEPT.
- ACCEPT: in_ready=1. On handshake, latch in_data to data_reg and in_last to last_reg; go to BSTART.
- BSTART: core_next=1 for one cycle; reload guard; go to BWAIT.
- core_block is registered and stable from BSTART through BWAIT:
  - CBC encrypt: data_reg^chain_reg.
  - CBC decrypt: data_reg.
  - CTR: chain_reg.
- BWAIT: once guard==0 and core_ready==1, register out_data and go to OUTPUT.
  - CBC encrypt: out_data=core_result; chain_reg<=core_result.
  - CBC decrypt: out_data=core_result^chain_reg; chain_reg<=data_reg.
  - CTR: out_data=core_result^data_reg; chain_reg[CTR_WIDTH-1:0]+=1, wrapping mod 2^CTR_WIDTH.
- OUTPUT: out_valid=1; out_data and out_last are held stable until out_ready.
  - On handshake with last_reg=1: done pulses next cycle; go to IDLE.
  - Otherwise go to ACCEPT.
- One block in flight; no input/output overlap. Back-to-back blocks cost 3 cycles plus core latency.
- core_encdec=encdec in CBC; forced to 1 in CTR. core_key/core_keylen are driven from latched values, stable for the whole message.
- start while busy: ignored. Key change requires a new message.
- abort: same cycle as any state returns IDLE next edge; out_valid/in_ready drop; done not pulsed. A core operation in progress is left to finish, and its result is discarded.
- abort and start in the same cycle: abort wins.
- reset_n low mid-operation: immediate return to reset values.
- mode=1 without AES_MODE_CTR_EN: treated as CBC.

Optional Feature:
- Macro AES_MODE_CTR_EN.
- Defined: CTR mode as above, including counter register increment logic.
- Undefined: mode input is unused, CTR datapath and incrementer are not built, and operation is always CBC.

Decomposition:
- Package aes_mode_pkg:
  - state enum (IDLE, KINIT, KWAIT, ACCEPT, BSTART, BWAIT, OUTPUT);
  - MODE_CBC=0, MODE_CTR=1;
  - AES_BLOCK_W=128, AES_KEY_W=256.
- Sub-module aes_mode_chain: chain_reg/data_reg, XOR muxes, counter increment, and out_data register.
- The FSM stays in aes_mode_ctrl.

Test Plan:
- CBC-AES128 encrypt:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c in [255:128], iv 000102030405060708090a0b0c0d0e0f, block 6bc1bee22e409f96e93d7e117393172a, last=1.
  - Required: out_data 7649abac8119b246cee98e9b12e9197d, out_last=1, single-cycle done pulse.
- CBC decrypt, 2-block message: decrypting the ciphertext from the encrypt case returns the original plaintext. The second block must use the first ciphertext as chain.
- CTR (macro on):
  - Stimulus: key as above, counter f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, PT 6bc1bee22e409f96e93d7e117393172a.
  - Required: out 874d6191b620e3261bef6864990db6ce; next core_block ends ...fcfdff00, upper 96 bits unchanged.
- Counter wrap: low 32 bits ffffffff followed by a second block -> low word 00000000, upper bits unchanged.
- Output backpressure: out_ready held low 20 cycles -> out_valid/out_data stable, in_ready=0 and no core_next throughout.
- abort asserted in BWAIT -> IDLE next cycle, busy=0, no out_valid, no done. A new start then completes the CBC vector correctly.
